// File: rtl/versat_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : versat_stream_pkg
// Description : Shared types and helpers for the Versat stream adder:
//               FSM state encoding, internal sum width, signed limits.
// Revision    : 1.0 - initial release
// ============================================================================
package versat_stream_pkg;

  // Sequencer states, 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  // Accumulator width: one guard bit per doubling of channels plus one for
  // negating the most negative input without overflow.
  function automatic int sum_w(input int data_w, input int num_in);
    return data_w + $clog2(num_in) + 1;
  endfunction

  // Largest signed value representable in data_w bits
  function automatic logic signed [63:0] smax(input int data_w);
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in data_w bits
  function automatic logic signed [63:0] smin(input int data_w);
    return -(64'sd1 <<< (data_w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/versat_sat_sum.sv
`default_nettype none
// ============================================================================
// Module      : versat_sat_sum
// Description : Combinational NUM_IN-input signed add/subtract with optional
//               signed saturation to DATA_W and a clamp indication.
// Revision    : 1.0 - initial release
// ============================================================================
module versat_sat_sum
  import versat_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*DATA_W-1:0] in_data_i,
  input  logic [NUM_IN-1:0]        sub_mask_i,
  input  logic                     sat_en_i,
  output logic [DATA_W-1:0]        sum_o,
  output logic                     ovf_o
);

  localparam int SUM_W = sum_w(DATA_W, NUM_IN);

  localparam logic signed [SUM_W-1:0] c_max = SUM_W'(smax(DATA_W));
  localparam logic signed [SUM_W-1:0] c_min = SUM_W'(smin(DATA_W));

  logic signed [SUM_W-1:0] w_ext [NUM_IN];
  logic signed [SUM_W-1:0] w_acc;

  // Sign-extend every channel to the accumulator width
  for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
    assign w_ext[k] = {{(SUM_W-DATA_W){in_data_i[k*DATA_W + DATA_W - 1]}},
                       in_data_i[k*DATA_W +: DATA_W]};
  end

  // Full-precision sum, then clamp or truncate to the output width
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sub_mask_i[k]) w_acc = w_acc - w_ext[k];
      else               w_acc = w_acc + w_ext[k];
    end
    sum_o = w_acc[DATA_W-1:0];
    ovf_o = 1'b0;
    if (sat_en_i && (w_acc > c_max)) begin
      sum_o = c_max[DATA_W-1:0];
      ovf_o = 1'b1;
    end else if (sat_en_i && (w_acc < c_min)) begin
      sum_o = c_min[DATA_W-1:0];
      ovf_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/versat_stream_adder.sv
`default_nettype none
// ============================================================================
// Module      : versat_stream_adder
// Description : Versat run/done sequenced NUM_IN-channel stream adder with
//               start delay, programmable length, wrap/saturate modes,
//               registered output with write strobe and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module versat_stream_adder
  import versat_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  output logic                     done,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        sub_mask,
  input  logic                     sat_en,
  input  logic [CNT_W-1:0]         delay,
  input  logic [CNT_W-1:0]         length,
  output logic [DATA_W-1:0]        out0,
  output logic                     out_valid,
  output logic                     ovf
);

  state_e              state_q;
  logic [CNT_W-1:0]    dly_cnt_q;
  logic [CNT_W-1:0]    smp_cnt_q;
  logic [CNT_W-1:0]    delay_q;
  logic [CNT_W-1:0]    length_q;
  logic [NUM_IN-1:0]   sub_mask_q;
  logic                sat_en_q;
  logic                done_q;
  logic [DATA_W-1:0]   out0_q;
  logic                out_valid_q;
  logic                ovf_q;

  logic [DATA_W-1:0]   w_sum;
  logic                w_ovf;

  // Adder tree works on the latched run configuration, never the live ports
  versat_sat_sum #(
    .DATA_W (DATA_W),
    .NUM_IN (NUM_IN)
  ) u_sum (
    .in_data_i  (in_data),
    .sub_mask_i (sub_mask_q),
    .sat_en_i   (sat_en_q),
    .sum_o      (w_sum),
    .ovf_o      (w_ovf)
  );

  // Sequencer FSM, counters, config latches and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dly_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      delay_q     <= '0;
      length_q    <= '0;
      sub_mask_q  <= '0;
      sat_en_q    <= 1'b0;
      done_q      <= 1'b1;
      out0_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            delay_q    <= delay;
            length_q   <= length;
            sub_mask_q <= sub_mask;
            sat_en_q   <= sat_en;
            ovf_q      <= 1'b0;
            // First WAIT cycle already counts as delay cycle 1
            dly_cnt_q  <= CNT_W'(1);
            smp_cnt_q  <= '0;
            if (length != '0) begin
              done_q  <= 1'b0;
              state_q <= (delay == '0) ? ST_SAMPLE : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Equality test before increment keeps delay=2^CNT_W-1 in range
          if (dly_cnt_q == delay_q) state_q   <= ST_SAMPLE;
          else                      dly_cnt_q <= dly_cnt_q + CNT_W'(1);
        end
        ST_SAMPLE: begin
          out0_q      <= w_sum;
          out_valid_q <= 1'b1;
          if (w_ovf) ovf_q <= 1'b1;
          // Counter runs 0..length-1 so it never reaches 2^CNT_W
          if (smp_cnt_q == length_q - CNT_W'(1)) state_q   <= ST_FLUSH;
          else                                   smp_cnt_q <= smp_cnt_q + CNT_W'(1);
        end
        ST_FLUSH: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign out0      = out0_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire
